// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the four-way round-robin mux arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   N_REQ       : number of requesters (fixed at 4, select is 2 bits)
//   SEL_W       : width of the mux select / requester index
//   onehot()    : converts a requester index into a one-hot grant vector
package mux4_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker for four requesters.
// Scans i_req starting at i_ptr and wrapping modulo 4; the first set bit wins.
//   i_req [3:0] : request vector
//   i_ptr [1:0] : index with highest priority this round
//   o_any       : at least one request is set
//   o_idx [1:0] : winning index (equals i_ptr when o_any is low)
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_any,
    output logic [SEL_W-1:0] o_idx
);

    always_comb begin
        o_any = 1'b0;
        o_idx = i_ptr;
        // Walk from the farthest offset back to offset 0 so that the candidate
        // closest to i_ptr is the last one written and therefore wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            logic [SEL_W-1:0] cand;
            cand = i_ptr + SEL_W'(i);
            if (i_req[cand]) begin
                o_any = 1'b1;
                o_idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters.
// Grants one requester at a time, drives the mux select and forwards the
// granted requester's beats downstream. A grant ends on an accepted final
// beat, when the requester drops its request, or after MAX_BEATS accepted
// beats, so no requester can hold the mux indefinitely.
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both high. out_valid depends only on the granted request (never on
// out_ready); out_ready while out_valid is low has no effect.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous reset, active high
//   req  [3:0] : per-requester request, held while beats remain
//   last [3:0] : per-requester final-beat marker (only granted index used)
//   out_ready  : downstream accepts a beat this cycle
//   gnt  [3:0] : one-hot grant, registered
//   sel  [1:0] : mux select, registered, index of gnt (held between grants)
//   out_valid  : beat valid toward downstream
//   out_last   : current beat ends the grant
//   busy       : high while in GRANT state (exposes the FSM state)
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    input  logic             out_ready,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

    if (MAX_BEATS < 1 || MAX_BEATS > 255 || (2 ** CNT_W) <= MAX_BEATS) begin : g_bad_params
        $error("mux4_rr_arbiter: MAX_BEATS must be 1..255 and fit in CNT_W bits");
    end

    arb_state_e       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_beat_cnt;

    arb_state_e       w_state_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_any;
    logic [SEL_W-1:0] w_idx;
    logic             w_in_grant;
    logic             w_req_sel;
    logic             w_valid;
    logic             w_cnt_max;
    logic             w_last_beat;
    logic             w_accept;
    logic             w_release;

    rr_pick4 u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    assign w_in_grant  = (r_state == GRANT);
    assign w_req_sel   = req[r_sel];
    assign w_valid     = w_in_grant & w_req_sel;
    assign w_cnt_max   = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign w_last_beat = w_valid & (last[r_sel] | w_cnt_max);
    assign w_accept    = w_valid & out_ready;
    // Withdrawal implies no beat was accepted, since out_valid was low.
    assign w_release   = (w_accept & w_last_beat) | ~w_req_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = onehot(w_idx);
                    w_sel_nxt   = w_idx;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    // Just-served index drops to lowest priority next round.
                    w_ptr_nxt   = r_sel + 1'b1;
                end else if (w_accept) begin
                    w_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign busy      = w_in_grant;
    assign out_valid = w_valid;
    assign out_last  = w_last_beat;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_busy    : assert property (@(posedge clk) disable iff (rst) ((gnt != '0) == busy));
    a_valid_busy  : assert property (@(posedge clk) disable iff (rst) (out_valid |-> busy));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. Inputs change and outputs are sampled
// on the falling clock edge; the design updates on the rising edge.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       out_ready;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_last;
    logic       busy;

    int n_checks;
    int n_errors;
    int n_acc;
    int last_no;

    mux4_rr_arbiter #(.MAX_BEATS(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; last = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge while a grant to idx is active. Drives last on
    // beat number last_at (0 = never) plus the noise bits on other indices,
    // counts accepted beats and returns once the grant has dropped.
    task automatic beat_loop(input logic [1:0] idx, input int last_at,
                             input logic [3:0] noise, input int budget,
                             output int acc, output int lst);
        logic [3:0] own;
        own = 4'b0001 << idx;
        acc = 0;
        lst = 0;
        for (int k = 0; k < budget; k++) begin
            last = (noise & ~own) | (((acc + 1) == last_at) ? own : 4'b0000);
            #1;
            if (out_valid && out_ready) begin
                acc++;
                if (out_last) lst = acc;
            end
            @(negedge clk);
            if (!busy) break;
        end
        last = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req = '0; last = '0; out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0)
            begin n_errors++; $display("FAIL reset_state: gnt=%b sel=%0d busy=%b ov=%b ol=%b, want 0000 0 0 0 0", gnt, sel, busy, out_valid, out_last); end
        do_reset();
        // Grant index 0 and accept two beats.
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001) begin n_errors++; $display("FAIL reset_pre_grant: gnt=%b want 0001", gnt); end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut.r_beat_cnt !== 8'd2) begin n_errors++; $display("FAIL reset_pre_cnt: cnt=%0d want 2", dut.r_beat_cnt); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0011;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 || dut.r_beat_cnt !== 8'd0)
            begin n_errors++; $display("FAIL reset_mid_grant: gnt=%b sel=%0d busy=%b ov=%b cnt=%0d, want 0000 0 0 0 0", gnt, sel, busy, out_valid, dut.r_beat_cnt); end
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin n_errors++; $display("FAIL reset_ptr: gnt=%b sel=%0d want 0001 0", gnt, sel); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1)
            begin n_errors++; $display("FAIL single_grant: gnt=%b sel=%0d busy=%b want 0100 2 1", gnt, sel, busy); end
        beat_loop(2'd2, 3, 4'b0000, 20, n_acc, last_no);
        req = '0;
        n_checks++;
        if (n_acc !== 3 || last_no !== 3) begin n_errors++; $display("FAIL single_beats: beats=%0d last_on=%0d want 3 3", n_acc, last_no); end
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd2)
            begin n_errors++; $display("FAIL single_release: gnt=%b busy=%b sel=%0d want 0000 0 2", gnt, busy, sel); end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_idx;
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            exp_idx = 2'(g % 4);
            n_checks++;
            if (gnt !== (4'b0001 << exp_idx) || sel !== exp_idx)
                begin n_errors++; $display("FAIL rot_grant%0d: gnt=%b sel=%0d want idx %0d", g, gnt, sel, exp_idx); end
            beat_loop(exp_idx, 1, 4'b0000, 10, n_acc, last_no);
            n_checks++;
            if (n_acc !== 1 || last_no !== 1)
                begin n_errors++; $display("FAIL rot_beats%0d: beats=%0d last_on=%0d want 1 1", g, n_acc, last_no); end
            n_checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0)
                begin n_errors++; $display("FAIL rot_bubble%0d: gnt=%b busy=%b want 0000 0", g, gnt, busy); end
            @(negedge clk);
        end
        req = '0;
    endtask

    task automatic test_forced_release();
        do_reset();
        req = 4'b0010; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010) begin n_errors++; $display("FAIL forced_grant: gnt=%b want 0010", gnt); end
        // last driven high on every non-granted index: must be ignored.
        beat_loop(2'd1, 0, 4'b1101, 30, n_acc, last_no);
        n_checks++;
        if (n_acc !== 8 || last_no !== 8) begin n_errors++; $display("FAIL forced_beats: beats=%0d last_on=%0d want 8 8", n_acc, last_no); end
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin n_errors++; $display("FAIL forced_release: gnt=%b busy=%b want 0000 0", gnt, busy); end
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010 || sel !== 2'd1 || dut.r_beat_cnt !== 8'd0)
            begin n_errors++; $display("FAIL forced_regrant: gnt=%b sel=%0d cnt=%0d want 0010 1 0", gnt, sel, dut.r_beat_cnt); end
        req = '0;
    endtask

    task automatic test_backpressure();
        logic       rdy_pat [4];
        logic [7:0] exp_cnt;
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        exp_cnt = '0;
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin n_errors++; $display("FAIL bp_grant: gnt=%b sel=%0d want 1000 3", gnt, sel); end
        for (int k = 0; k < 4; k++) begin
            out_ready = rdy_pat[k];
            #1;
            n_checks++;
            if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid%0d: out_valid=%b want 1", k, out_valid); end
            if (rdy_pat[k]) exp_cnt++;
            @(negedge clk);
            n_checks++;
            if (dut.r_beat_cnt !== exp_cnt) begin n_errors++; $display("FAIL bp_cnt%0d: cnt=%0d want %0d", k, dut.r_beat_cnt, exp_cnt); end
        end
        out_ready = 1'b0;
        req = '0;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin n_errors++; $display("FAIL bp_release: gnt=%b busy=%b want 0000 0", gnt, busy); end
    endtask

    task automatic test_withdrawal();
        do_reset();
        req = 4'b0111; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001) begin n_errors++; $display("FAIL wd_grant: gnt=%b want 0001", gnt); end
        @(negedge clk);
        req = 4'b0110;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0)
            begin n_errors++; $display("FAIL wd_valid: out_valid=%b out_last=%b want 0 0", out_valid, out_last); end
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin n_errors++; $display("FAIL wd_release: gnt=%b busy=%b want 0000 0", gnt, busy); end
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin n_errors++; $display("FAIL wd_next: gnt=%b sel=%0d want 0010 1", gnt, sel); end
        req = '0;
        out_ready = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single();
        test_rotation();
        test_forced_release();
        test_backpressure();
        test_withdrawal();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
